// File: rtl/miriscv_int_pkg.sv
// miriscv_int_pkg
//   Shared definitions for the interrupt controller slice: the controller
//   state enum, the interrupt-line limit, the mcause interrupt bit position
//   and a small index helper used by round-robin arbitration.
//   No ports.
package miriscv_int_pkg;

   localparam int unsigned INT_NUM_MAX    = 32;
   localparam int unsigned MCAUSE_INT_BIT = 31;
   localparam int unsigned ID_W           = 5;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      SERVE,
      FIN
   } int_state_e;

   // Next index after idx, wrapping to 0 at n.
   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx,
                                                input int unsigned     n);
      if (32'(idx) + 32'd1 >= n) return '0;
      return idx + 5'd1;
   endfunction

endpackage

// File: rtl/miriscv_int_ctrl_if.sv
// miriscv_int_ctrl_if
//   Bundles the interrupt request/enable lines and the core trap handshake.
//   Signals:
//     int_req_i  [INT_NUM] level requests from interrupt sources
//     mie_i      [INT_NUM] per-line enable mask from the CSR file
//     int_o                trap request to the core
//     mcause_o   [32]      cause value for the core
//     int_ack_i            core has taken the trap
//     int_done_i           core executed mret
//     int_fin_o  [INT_NUM] one-hot completion pulse to the serviced source
//   Modports: master (core/CSR/source side), slave (controller side).
interface miriscv_int_ctrl_if #(
   parameter int unsigned INT_NUM = 32
);

   logic [INT_NUM-1:0] int_req_i;
   logic [INT_NUM-1:0] mie_i;
   logic               int_o;
   logic [31:0]        mcause_o;
   logic               int_ack_i;
   logic               int_done_i;
   logic [INT_NUM-1:0] int_fin_o;

   modport master (
      output int_req_i, mie_i, int_ack_i, int_done_i,
      input  int_o, mcause_o, int_fin_o
   );

   modport slave (
      input  int_req_i, mie_i, int_ack_i, int_done_i,
      output int_o, mcause_o, int_fin_o
   );

endinterface

// File: rtl/miriscv_int_prio_enc.sv
// miriscv_int_prio_enc
//   Circular priority encoder: searches req_i starting at start_i, wrapping
//   modulo INT_NUM, and returns the first set index.
//   Ports:
//     req_i   [INT_NUM] candidate lines
//     start_i [5]       first index to examine (must be < INT_NUM)
//     valid_o           some bit of req_i is set
//     idx_o   [5]       winning index (0 when valid_o=0)
module miriscv_int_prio_enc
   import miriscv_int_pkg::*;
#(
   parameter int unsigned INT_NUM = 32
) (
   input  logic [INT_NUM-1:0] req_i,
   input  logic [ID_W-1:0]    start_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    idx_o
);

   always_comb begin
      int unsigned        pos;
      logic [INT_NUM-1:0] shifted;
      valid_o = 1'b0;
      idx_o   = '0;
      pos     = 0;
      shifted = '0;
      for (int unsigned i = 0; i < INT_NUM; i++) begin
         pos = 32'(start_i) + i;
         if (pos >= INT_NUM) pos = pos - INT_NUM;
         shifted = req_i >> pos;
         if (!valid_o && shifted[0]) begin
            valid_o = 1'b1;
            idx_o   = pos[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/miriscv_int_ctrl.sv
// miriscv_int_ctrl
//   Interrupt controller: arbitrates enabled level requests, raises a trap
//   request to the core, tracks the ack/mret handshake and pulses a one-hot
//   completion back to the serviced source.
//   Ports:
//     clk_i   system clock, rising edge
//     rst_i   asynchronous active-high reset
//     bus     miriscv_int_ctrl_if.slave (requests, mask, trap handshake)
//   Build option:
//     MIRISCV_INT_RR_EN  defined   -> round-robin arbitration
//                        undefined -> fixed priority, lowest index wins
module miriscv_int_ctrl
   import miriscv_int_pkg::*;
#(
   parameter int unsigned INT_NUM = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   miriscv_int_ctrl_if.slave bus
);

   int_state_e         state_q, state_d;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    start_idx;
   logic [INT_NUM-1:0] eligible;
   logic               arb_valid;
   logic [ID_W-1:0]    arb_idx;

   always_comb eligible = bus.int_req_i & bus.mie_i;

`ifdef MIRISCV_INT_RR_EN
   logic [ID_W-1:0] rr_ptr_q;

   // Pointer moves only on entry to FIN, so the next search begins just
   // past the line that was last completed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rr_ptr_q <= '0;
      else if (state_q == SERVE && bus.int_done_i) rr_ptr_q <= wrap_inc(id_q, INT_NUM);
   end

   always_comb start_idx = rr_ptr_q;
`else
   always_comb start_idx = '0;
`endif

   miriscv_int_prio_enc #(
      .INT_NUM (INT_NUM)
   ) u_prio_enc (
      .req_i   (eligible),
      .start_i (start_idx),
      .valid_o (arb_valid),
      .idx_o   (arb_idx)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // The arbiter result is consumed only in IDLE, so the line being
   // completed in FIN never competes and back-to-back services are always
   // separated by an IDLE cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (arb_valid)      state_d = PEND;
         PEND:    if (bus.int_ack_i)  state_d = SERVE;
         SERVE:   if (bus.int_done_i) state_d = FIN;
         FIN:                         state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) id_q <= '0;
      else if (state_q == IDLE && arb_valid) id_q <= arb_idx;
   end

   always_comb begin
      bus.int_o                    = (state_q == PEND);
      bus.mcause_o                 = '0;
      bus.mcause_o[MCAUSE_INT_BIT] = 1'b1;
      bus.mcause_o[ID_W-1:0]       = id_q;
      bus.int_fin_o                = '0;
      if (state_q == FIN) bus.int_fin_o = INT_NUM'(1) << id_q;
   end

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// tb_miriscv_int_ctrl
//   Self-checking bench for miriscv_int_ctrl. Expected mcause values are
//   queued when a request is driven and expected completion vectors when
//   mret is driven; a negedge monitor pops and compares them when int_o
//   rises or int_fin_o pulses.
module tb_miriscv_int_ctrl;

   localparam int unsigned N = 32;

   logic clk;
   logic rst;

   int unsigned checks;
   int unsigned failures;

   logic [31:0] cause_q[$];
   logic [31:0] fin_q[$];
   logic        int_o_prev;

   int unsigned exp_seq[4];

   miriscv_int_ctrl_if #(.INT_NUM(N)) bus ();

   miriscv_int_ctrl #(
      .INT_NUM (N)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] cause_of(input int unsigned id);
      return 32'h8000_0000 | (id & 32'h1f);
   endfunction

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst) begin
         int_o_prev = 1'b0;
      end else begin
         if (bus.int_o && !int_o_prev) begin
            if (cause_q.size() == 0) chk("spurious_int", 32'd1, 32'd0);
            else                     chk("mcause", bus.mcause_o, cause_q.pop_front());
         end
         if (bus.int_fin_o != '0) begin
            if (fin_q.size() == 0) chk("spurious_fin", bus.int_fin_o, 32'd0);
            else                   chk("fin", bus.int_fin_o, fin_q.pop_front());
         end
         int_o_prev = bus.int_o;
      end
   end

   // One complete service. Called at a negedge with the DUT in IDLE; returns
   // at a negedge with the DUT back in IDLE. post_req is what the sources
   // present once the completion pulse is out.
   task automatic run_irq(input logic [31:0] req, input logic [31:0] mie,
                          input int unsigned exp_id, input bit drop_pend,
                          input logic [31:0] post_req);
      bus.int_req_i = req;
      bus.mie_i     = mie;
      cause_q.push_back(cause_of(exp_id));
      @(negedge clk);
      chk("int_o_latency", {31'b0, bus.int_o}, 32'd1);
      if (drop_pend) begin
         bus.int_req_i = '0;
         bus.mie_i     = '0;
         @(negedge clk);
         chk("int_o_after_drop", {31'b0, bus.int_o}, 32'd1);
      end
      bus.int_ack_i  = 1'b1;
      bus.int_done_i = drop_pend;
      @(negedge clk);
      chk("serve_int_o", {31'b0, bus.int_o}, 32'd0);
      chk("serve_mcause", bus.mcause_o, cause_of(exp_id));
      chk("serve_no_fin", bus.int_fin_o, 32'd0);
      bus.int_done_i = 1'b0;
      @(negedge clk);
      bus.int_ack_i = 1'b0;
      chk("serve_ack_ignored", bus.int_fin_o | {31'b0, bus.int_o}, 32'd0);
      repeat (4) @(negedge clk);
      fin_q.push_back(32'h1 << exp_id);
      bus.int_done_i = 1'b1;
      @(negedge clk);
      bus.int_done_i = 1'b0;
      bus.int_req_i  = post_req;
      @(negedge clk);
      chk("idle_fin_cleared", bus.int_fin_o, 32'd0);
      chk("idle_int_o", {31'b0, bus.int_o}, 32'd0);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      int_o_prev    = 1'b0;
      rst           = 1'b1;
      bus.int_req_i = '0;
      bus.mie_i     = '0;
      bus.int_ack_i  = 1'b0;
      bus.int_done_i = 1'b0;
`ifdef MIRISCV_INT_RR_EN
      exp_seq = '{3, 7, 3, 7};
`else
      exp_seq = '{3, 3, 3, 3};
`endif

      @(negedge clk);
      chk("rst_int_o", {31'b0, bus.int_o}, 32'd0);
      chk("rst_fin", bus.int_fin_o, 32'd0);
      chk("rst_mcause", bus.mcause_o, 32'h8000_0000);
      @(negedge clk);
      rst = 1'b0;

      // Line 19, full handshake.
      run_irq(32'h0008_0000, '1, 19, 1'b0, 32'h0);

      // Masked line 3 loses to enabled line 5 and is never served.
      run_irq(32'h0000_0028, 32'h0000_0020, 5, 1'b0, 32'h0000_0008);
      repeat (3) begin
         @(negedge clk);
         chk("masked_line3", {31'b0, bus.int_o}, 32'd0);
      end
      bus.int_req_i = '0;

      // Request and mask drop in PEND; ack+done together go only to SERVE.
      run_irq(32'h0008_0000, '1, 19, 1'b1, 32'h0);

      // Lines 3 and 7 held high continuously.
      for (int k = 0; k < 4; k++)
         run_irq(32'h0000_0088, '1, exp_seq[k], 1'b0, (k < 3) ? 32'h0000_0088 : 32'h0);

      // Reset in SERVE aborts the service without a completion pulse.
      bus.int_req_i = 32'h0000_0400;
      bus.mie_i     = '1;
      cause_q.push_back(cause_of(10));
      @(negedge clk);
      chk("int_o_latency_10", {31'b0, bus.int_o}, 32'd1);
      bus.int_ack_i = 1'b1;
      @(negedge clk);
      bus.int_ack_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_int_o", {31'b0, bus.int_o}, 32'd0);
      chk("abort_fin", bus.int_fin_o, 32'd0);
      chk("abort_mcause", bus.mcause_o, 32'h8000_0000);
      bus.int_req_i = '0;
      @(negedge clk);
      rst = 1'b0;
      bus.int_done_i = 1'b1;
      @(negedge clk);
      bus.int_done_i = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_fin", bus.int_fin_o | {31'b0, bus.int_o}, 32'd0);
      end

      chk("sb_cause_empty", cause_q.size(), 32'd0);
      chk("sb_fin_empty", fin_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
